// File: rtl/mio_bus_ctrl_if.sv
// CPU-side request/response bus between the single-cycle core and mio_bus_ctrl.
interface mio_bus_ctrl_if;
    logic        cpu_mio;
    logic        mem_rw;
    logic [31:0] addr_in;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        mio_ready;

    modport master (
        output cpu_mio, mem_rw, addr_in, data_wr,
        input  data_rd, mio_ready
    );

    modport slave (
        input  cpu_mio, mem_rw, addr_in, data_wr,
        output data_rd, mio_ready
    );
endinterface

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: decodes CPU accesses to RAM, on-chip registers or the IO port.
// Optional MIO_TIMEOUT_EN adds an IO_WAIT timeout counter and the sticky bus_err flag.
module mio_bus_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mio_bus_ctrl_if.slave bus,
    output logic          ram_we,
    output logic [9:0]    ram_addr,
    output logic [31:0]   ram_din,
    input  logic [31:0]   ram_dout,
    output logic          io_req,
    output logic          io_we,
    output logic [5:0]    io_addr,
    output logic [31:0]   io_wdata,
    input  logic          io_ack,
    input  logic [31:0]   io_rdata,
    input  logic [15:0]   sw_in,
    output logic [15:0]   led_out,
    output logic          bus_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RAM_RD  = 2'd1;
    localparam logic [1:0] S_IO_WAIT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mio_bus_ctrl: TIMEOUT must be at least 1");
    end

    logic [1:0]  state_q, state_d;
    logic        mio_ready_q, mio_ready_d;
    logic [31:0] data_rd_q, data_rd_d;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic        io_req_q, io_req_d;
    logic        io_we_q, io_we_d;
    logic [5:0]  io_addr_q, io_addr_d;
    logic [31:0] io_wdata_q, io_wdata_d;
    logic        err_c;
    logic        hit_ram_c, hit_io_c, hit_reg_c, accept_c;
    logic [31:0] reg_rdata_c;
    logic        unused_addr_lsb;

`ifdef MIO_TIMEOUT_EN
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      TMO_DATA = 32'hDEAD_BEEF;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             tmo_c;

    assign tmo_c = (cnt_q == CNT_LAST);
    assign err_c = err_q;
`else
    assign err_c = 1'b0;
`endif

    // Address decode; bits [1:0] are byte offsets and never matter.
    assign hit_ram_c       = (bus.addr_in[31:12] == 20'h0_0000);
    assign hit_io_c        = (bus.addr_in[31:8]  == 24'hE0_0000);
    assign hit_reg_c       = (bus.addr_in[31:4]  == 28'hF00_0000);
    assign accept_c        = (state_q == S_IDLE) && bus.cpu_mio && !rst;
    assign unused_addr_lsb = ^bus.addr_in[1:0];

    assign ram_we   = accept_c && hit_ram_c && bus.mem_rw;
    assign ram_addr = bus.addr_in[11:2];
    assign ram_din  = bus.data_wr;

    always_comb begin
        case (bus.addr_in[3:2])
            2'd0:    reg_rdata_c = {16'h0000, led_q};
            2'd1:    reg_rdata_c = {16'h0000, sw_in};
            2'd2:    reg_rdata_c = timer_q;
            default: reg_rdata_c = {31'h0, err_c};
        endcase
    end

    // Next-state, datapath and register-write logic.
    always_comb begin
        state_d    = state_q;
        data_rd_d  = data_rd_q;
        led_d      = led_q;
        timer_d    = timer_q + 32'd1;
        io_req_d   = io_req_q;
        io_we_d    = io_we_q;
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
`ifdef MIO_TIMEOUT_EN
        cnt_d      = '0;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (hit_ram_c && !bus.mem_rw) begin
                        state_d = S_RAM_RD;
                    end else if (hit_io_c) begin
                        state_d    = S_IO_WAIT;
                        io_req_d   = 1'b1;
                        io_we_d    = bus.mem_rw;
                        io_addr_d  = bus.addr_in[7:2];
                        io_wdata_d = bus.data_wr;
                    end else begin
                        state_d = S_DONE;
                        if (!bus.mem_rw) begin
                            data_rd_d = hit_reg_c ? reg_rdata_c : 32'h0;
                        end else if (hit_reg_c) begin
                            case (bus.addr_in[3:2])
                                2'd0: led_d   = bus.data_wr[15:0];
                                2'd2: timer_d = bus.data_wr;
`ifdef MIO_TIMEOUT_EN
                                2'd3: if (bus.data_wr[0]) err_d = 1'b0;
`endif
                                default: ;
                            endcase
                        end
                    end
                end
            end
            S_RAM_RD: begin
                data_rd_d = ram_dout;
                state_d   = S_DONE;
            end
            S_IO_WAIT: begin
`ifdef MIO_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (io_ack) begin
                    data_rd_d = io_rdata;
                    io_req_d  = 1'b0;
                    state_d   = S_DONE;
`ifdef MIO_TIMEOUT_EN
                end else if (tmo_c) begin
                    data_rd_d = TMO_DATA;
                    err_d     = 1'b1;
                    io_req_d  = 1'b0;
                    state_d   = S_DONE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
        mio_ready_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mio_ready_q <= 1'b0;
            data_rd_q   <= '0;
            led_q       <= '0;
            timer_q     <= '0;
            io_req_q    <= 1'b0;
            io_we_q     <= 1'b0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mio_ready_q <= mio_ready_d;
            data_rd_q   <= data_rd_d;
            led_q       <= led_d;
            timer_q     <= timer_d;
            io_req_q    <= io_req_d;
            io_we_q     <= io_we_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
        end
    end

`ifdef MIO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign bus.data_rd   = data_rd_q;
    assign bus.mio_ready = mio_ready_q;
    assign led_out       = led_q;
    assign io_req        = io_req_q;
    assign io_we         = io_we_q;
    assign io_addr       = io_addr_q;
    assign io_wdata      = io_wdata_q;
    assign bus_err       = err_c;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Randomized transaction bench for mio_bus_ctrl against a transaction-level reference model.
module tb_mio_bus_ctrl;
    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;
    logic        io_req, io_we, io_ack;
    logic [5:0]  io_addr;
    logic [31:0] io_wdata, io_rdata;
    logic [15:0] sw_in, led_out;
    logic        bus_err;

    mio_bus_ctrl_if bus ();

    mio_bus_ctrl #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
        .io_ack(io_ack), .io_rdata(io_rdata),
        .sw_in(sw_in), .led_out(led_out), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read block RAM attached to the controller.
    logic [31:0] ram_mem [1024];
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
        else if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Reference model state and per-cycle expectations.
    logic [31:0] m_mem [1024];
    logic [15:0] m_led;
    logic        m_err;
    logic [31:0] m_data, tmr_base;
    int          tmr_cyc;
    logic        e_ready, e_ram_we, e_io_req, e_io_we;
    logic [9:0]  e_ram_addr;
    logic [5:0]  e_io_addr;
    logic [31:0] e_ram_din, e_io_wdata;
    bit          check_en = 1'b0;
    bit          sw_hold = 1'b0;
    int          n_vec = 0;
    int          n_bad = 0;
    int          req_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("mio_ready", 32'(bus.mio_ready), 32'(e_ready));
            chk("data_rd", bus.data_rd, m_data);
            chk("led_out", 32'(led_out), 32'(m_led));
            chk("bus_err", 32'(bus_err), 32'(m_err));
            chk("ram_we", 32'(ram_we), 32'(e_ram_we));
            chk("io_req", 32'(io_req), 32'(e_io_req));
            if (e_ram_we) begin
                chk("ram_addr", 32'(ram_addr), 32'(e_ram_addr));
                chk("ram_din", ram_din, e_ram_din);
            end
            if (e_io_req) begin
                chk("io_addr", 32'(io_addr), 32'(e_io_addr));
                chk("io_we", 32'(io_we), 32'(e_io_we));
                chk("io_wdata", io_wdata, e_io_wdata);
            end
            if (io_req) req_cnt++;
        end
    end

    task automatic model_reset();
        m_led = '0; m_err = 1'b0; m_data = '0;
        tmr_base = '0; tmr_cyc = cyc;
        for (int i = 0; i < 1024; i++) m_mem[i] = '0;
        e_ready = 1'b0; e_ram_we = 1'b0; e_io_req = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        e_ready = 1'b0; e_ram_we = 1'b0; e_io_req = 1'b0;
        io_ack = 1'b0; io_rdata = $urandom;
        if (!sw_hold) sw_in = 16'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            bus.cpu_mio = 1'b0;
            bus.addr_in = $urandom;
        end
    endtask

    // One CPU access: expected latency, side effects and read data from the address map rules.
    task automatic txn(input logic rw, input logic [31:0] a, input logic [31:0] wd, input int d,
                       input logic [31:0] iod, output logic [31:0] rv, output int lat);
        int t, req_n;
        bit is_ram, is_io, is_reg, tmo, led_wr, err_clr;
        logic [31:0] val;
        next_cycle();
        t = cyc;
        bus.cpu_mio = 1'b1; bus.mem_rw = rw; bus.addr_in = a; bus.data_wr = wd;
        is_ram = (a < 32'h0000_1000);
        is_io  = (a >= 32'hE000_0000) && (a <= 32'hE000_00FF);
        is_reg = (a >= 32'hF000_0000) && (a <= 32'hF000_000F);
        val = m_data; led_wr = 1'b0; err_clr = 1'b0; tmo = 1'b0; req_n = 0;
`ifdef MIO_TIMEOUT_EN
        tmo = is_io && (d >= int'(TMO));
`endif
        if (is_io) begin
            req_n = tmo ? int'(TMO) : d + 1;
            lat   = req_n + 1;
            val   = tmo ? 32'hDEAD_BEEF : iod;
        end else if (is_ram && !rw) begin
            lat = 2;
            val = m_mem[a[11:2]];
        end else begin
            lat = 1;
            if (is_ram) begin
                m_mem[a[11:2]] = wd;
                e_ram_we = 1'b1; e_ram_addr = a[11:2]; e_ram_din = wd;
            end else if (is_reg && !rw) begin
                case (a[3:2])
                    2'd0:    val = {16'h0000, m_led};
                    2'd1:    val = {16'h0000, sw_in};
                    2'd2:    val = tmr_base + 32'(t - tmr_cyc);
                    default: val = {31'h0, m_err};
                endcase
            end else if (is_reg) begin
                case (a[3:2])
                    2'd0: led_wr = 1'b1;
                    2'd2: begin tmr_base = wd; tmr_cyc = t + 1; end
                    2'd3: err_clr = wd[0];
                    default: ;
                endcase
            end else if (!rw) begin
                val = '0;
            end
        end
        for (int k = 1; k <= lat; k++) begin
            next_cycle();
            bus.cpu_mio = 1'($urandom);
            if (k == 1) begin
                if (led_wr) m_led = wd[15:0];
                if (err_clr) m_err = 1'b0;
            end
            if (is_io && k <= req_n) begin
                e_io_req = 1'b1; e_io_addr = a[7:2]; e_io_we = rw; e_io_wdata = wd;
                if (!tmo && k == req_n) begin io_ack = 1'b1; io_rdata = iod; end
            end
            if (k == lat) begin
                e_ready = 1'b1;
                m_data = val;
                if (tmo) m_err = 1'b1;
            end
        end
        rv = val;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rv, a, wd;
        logic [31:0] unm_base [4];
        int lat, r, d;
        unm_base[0] = 32'h0000_1000; unm_base[1] = 32'hE000_0100;
        unm_base[2] = 32'hF000_0010; unm_base[3] = 32'h8000_0000;
        bus.cpu_mio = 1'b0; bus.mem_rw = 1'b0; bus.addr_in = '0; bus.data_wr = '0;
        io_ack = 1'b0; io_rdata = '0; sw_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_en = 1'b1;
        chk("reset_data_rd", bus.data_rd, 32'h0);
        chk("reset_ready", 32'(bus.mio_ready), 32'h0);
        chk("reset_led", 32'(led_out), 32'h0);
        chk("reset_io_req", 32'(io_req), 32'h0);

        // RAM write then read-back.
        txn(1'b1, 32'h0000_0010, 32'h1234_5678, 0, 32'h0, rv, lat);
        chk("ram_wr_lat", 32'(lat), 32'd1);
        txn(1'b0, 32'h0000_0010, 32'h0, 0, 32'h0, rv, lat);
        chk("ram_rd_data", bus.data_rd, 32'h1234_5678);
        chk("ram_rd_ready", 32'(bus.mio_ready), 32'h1);
        chk("ram_rd_lat", 32'(lat), 32'd2);

        // LED write, switch read.
        txn(1'b1, 32'hF000_0000, 32'h0000_ABCD, 0, 32'h0, rv, lat);
        chk("led_abcd", 32'(led_out), 32'h0000_ABCD);
        sw_in = 16'h00F0; sw_hold = 1'b1;
        txn(1'b0, 32'hF000_0004, 32'h0, 0, 32'h0, rv, lat);
        sw_hold = 1'b0;
        chk("sw_read", bus.data_rd, 32'h0000_00F0);
        chk("sw_lat", 32'(lat), 32'd1);

        // Timer load and wrap.
        txn(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, 0, 32'h0, rv, lat);
        txn(1'b0, 32'hF000_0008, 32'h0, 0, 32'h0, rv, lat);
        chk("timer_rd1", bus.data_rd, 32'hFFFF_FFFF);
        txn(1'b0, 32'hF000_0008, 32'h0, 0, 32'h0, rv, lat);
        chk("timer_wrap", bus.data_rd, 32'h0000_0001);

        // IO read with the ack three cycles into the request.
        req_cnt = 0;
        txn(1'b0, 32'hE000_0008, 32'h0, 2, 32'h0000_0055, rv, lat);
        chk("io_rd_data", bus.data_rd, 32'h0000_0055);
        chk("io_rd_lat", 32'(lat), 32'd4);
        chk("io_req_cycles", 32'(req_cnt), 32'd3);

`ifdef MIO_TIMEOUT_EN
        txn(1'b0, 32'hE000_0020, 32'h0, 1000, 32'h0, rv, lat);
        chk("tmo_data", bus.data_rd, 32'hDEAD_BEEF);
        chk("tmo_err", 32'(bus_err), 32'h1);
        chk("tmo_lat", 32'(lat), 32'(TMO + 1));
        txn(1'b0, 32'hF000_000C, 32'h0, 0, 32'h0, rv, lat);
        chk("err_reg_set", bus.data_rd, 32'h1);
        txn(1'b1, 32'hF000_000C, 32'h1, 0, 32'h0, rv, lat);
        chk("err_clear", 32'(bus_err), 32'h0);
        txn(1'b0, 32'hE000_0004, 32'h0, int'(TMO) - 1, 32'h0000_CAFE, rv, lat);
        chk("ack_at_limit", bus.data_rd, 32'h0000_CAFE);
        chk("ack_at_limit_err", 32'(bus_err), 32'h0);
`else
        txn(1'b0, 32'hF000_000C, 32'h0, 0, 32'h0, rv, lat);
        chk("err_reg_zero", bus.data_rd, 32'h0);
`endif

        // Reset while waiting on the IO port.
        txn(1'b1, 32'hF000_0000, 32'h0000_5A5A, 0, 32'h0, rv, lat);
        next_cycle();
        bus.cpu_mio = 1'b1; bus.mem_rw = 1'b0; bus.addr_in = 32'hE000_0010; bus.data_wr = 32'h0;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            bus.cpu_mio = 1'b0;
            e_io_req = 1'b1; e_io_addr = 6'd4; e_io_we = 1'b0; e_io_wdata = 32'h0;
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        model_reset();
        chk("rst_io_req", 32'(io_req), 32'h0);
        chk("rst_led", 32'(led_out), 32'h0);
        chk("rst_ready", 32'(bus.mio_ready), 32'h0);
        idle(2);

        // Accesses presented while reset is held have no effect.
        next_cycle();
        rst = 1'b1;
        bus.cpu_mio = 1'b1; bus.mem_rw = 1'b1; bus.addr_in = 32'h0000_0020; bus.data_wr = 32'hFFFF_FFFF;
        next_cycle();
        bus.addr_in = 32'hF000_0000;
        next_cycle();
        rst = 1'b0;
        bus.cpu_mio = 1'b0;
        model_reset();
        idle(1);
        chk("rst_no_led_wr", 32'(led_out), 32'h0);

        // Randomized traffic across all targets.
        repeat (250) begin
            r  = $urandom_range(0, 9);
            wd = $urandom;
            d  = 0;
            if (r <= 3) begin
                a = {20'h0, (r == 3) ? 10'($urandom) : 10'($urandom_range(0, 15)), 2'($urandom)};
            end else if (r <= 5) begin
                a = 32'hF000_0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            end else if (r <= 7) begin
                a = 32'hE000_0000 | 32'($urandom_range(0, 255));
                d = $urandom_range(0, 5);
            end else begin
                a = unm_base[$urandom_range(0, 3)] | 32'($urandom_range(0, 255));
            end
            txn(1'($urandom), a, wd, d, $urandom, rv, lat);
            idle($urandom_range(0, 2));
        end

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
